// File: rtl/fetch_queue.sv
// fetch_queue: 2-wide circular fetch->decode instruction buffer with flush and empty perf event
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic [1:0]               push_valid_i,
  input  logic [2*XLEN-1:0]        push_pc_i,
  input  logic [63:0]              push_instr_i,
  output logic                     push_ready_o,
  output logic [1:0]               pop_valid_o,
  output logic [2*XLEN-1:0]        pop_pc_o,
  output logic [63:0]              pop_instr_o,
  input  logic [1:0]               pop_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_event_o
);
  localparam int PW = $clog2(DEPTH);
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [PW:0]     rd_ptr, wr_ptr;
  logic [PW-1:0]   wi0, wi1, ri0, ri1;
  logic [1:0]      n_push, n_pop;
  assign count_o      = wr_ptr - rd_ptr;
  assign push_ready_o = count_o < (PW+1)'(DEPTH-1);
  assign pop_valid_o  = {|count_o[PW:1], |count_o};
  assign n_push       = push_ready_o & push_valid_i[0] ? (push_valid_i[1] ? 2'd2 : 2'd1) : 2'd0;
  assign n_pop        = 2'(pop_valid_o[0] & pop_ready_i[0]) + 2'(pop_valid_o[1] & pop_ready_i[0] & pop_ready_i[1]);
  assign wi0          = wr_ptr[PW-1:0];
  assign wi1          = PW'(wi0 + 1'b1);
  assign ri0          = rd_ptr[PW-1:0];
  assign ri1          = PW'(ri0 + 1'b1);
  assign pop_pc_o     = {mem_pc[ri1], mem_pc[ri0]};
  assign pop_instr_o  = {mem_instr[ri1], mem_instr[ri0]};
  // Payload storage needs no reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (!flush_i && n_push != 2'd0) begin
      mem_pc[wi0]    <= push_pc_i[XLEN-1:0];
      mem_instr[wi0] <= push_instr_i[31:0];
    end
    if (!flush_i && n_push == 2'd2) begin
      mem_pc[wi1]    <= push_pc_i[2*XLEN-1:XLEN];
      mem_instr[wi1] <= push_instr_i[63:32];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      empty_event_o <= 1'b0;
    end else begin
      rd_ptr        <= flush_i ? wr_ptr : rd_ptr + (PW+1)'(n_pop);
      wr_ptr        <= flush_i ? wr_ptr : wr_ptr + (PW+1)'(n_push);
      empty_event_o <= (count_o == '0) & ~flush_i;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a queue scoreboard of pushed {pc, instr} entries
module tb_fetch_queue;
  logic        clk = 0, reset = 1, flush_i = 0;
  logic [1:0]  push_valid_i = 0, pop_ready_i = 0, pop_valid_o;
  logic [63:0] push_pc_i = 0, push_instr_i = 0, pop_pc_o, pop_instr_o;
  logic        push_ready_o, empty_event_o;
  logic [3:0]  count_o;
  int checks = 0, errors = 0;
  logic [31:0] nx, saved;
  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t q[$];

  fetch_queue #(.XLEN(32), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_pc_i(push_pc_i), .push_instr_i(push_instr_i),
    .push_ready_o(push_ready_o), .pop_valid_o(pop_valid_o), .pop_pc_o(pop_pc_o),
    .pop_instr_o(pop_instr_o), .pop_ready_i(pop_ready_i), .count_o(count_o),
    .empty_event_o(empty_event_o));

  always #5 clk = ~clk;
  initial begin
    #200000;
    $error("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] insn(input logic [31:0] pc);
    return {pc[19:0], 12'h013};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] pv, input logic [31:0] p0, i0, p1, i1,
                     input logic [1:0] pr, input logic fl);
    int cnt, np, npop;
    push_valid_i = pv; push_pc_i = {p1, p0}; push_instr_i = {i1, i0};
    pop_ready_i = pr; flush_i = fl;
    #1;
    cnt = q.size();
    check("push_ready", 64'(push_ready_o), 64'(cnt <= 6));
    check("pop_valid", 64'(pop_valid_o), 64'({cnt >= 2, cnt >= 1}));
    if (cnt >= 1) begin
      check("pop_pc0", 64'(pop_pc_o[31:0]), 64'(q[0].pc));
      check("pop_ins0", 64'(pop_instr_o[31:0]), 64'(q[0].ins));
    end
    if (cnt >= 2) begin
      check("pop_pc1", 64'(pop_pc_o[63:32]), 64'(q[1].pc));
      check("pop_ins1", 64'(pop_instr_o[63:32]), 64'(q[1].ins));
    end
    np = (cnt <= 6 && pv[0]) ? (pv[1] ? 2 : 1) : 0;
    npop = int'(cnt >= 1 && pr[0]) + int'(cnt >= 2 && pr[0] && pr[1]);
    @(posedge clk); #1;
    if (fl) q.delete();
    else begin
      repeat (npop) void'(q.pop_front());
      if (np >= 1) q.push_back(ent_t'{pc: p0, ins: i0});
      if (np == 2) q.push_back(ent_t'{pc: p1, ins: i1});
    end
    check("empty_event", 64'(empty_event_o), 64'(cnt == 0 && !fl));
    check("count", 64'(count_o), 64'(q.size()));
  endtask

  task automatic pp(input logic [1:0] pv, input logic [1:0] pr);
    int c = q.size();
    cyc(pv, nx, insn(nx), nx + 4, insn(nx + 4), pr, 1'b0);
    if (c <= 6 && pv[0]) nx += pv[1] ? 8 : 4;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_pop_valid", 64'(pop_valid_o), 64'd0);
    check("rst_push_ready", 64'(push_ready_o), 64'd1);
    check("rst_empty_event", 64'(empty_event_o), 64'd0);
    @(posedge clk); #1;
    // basic push of two pairs
    cyc(2'b11, 32'h100, 32'h00000013, 32'h104, 32'h00100093, 2'b00, 1'b0);
    check("t1_count", 64'(count_o), 64'd2);
    check("t1_pop_valid", 64'(pop_valid_o), 64'b11);
    check("t1_pop_pc", pop_pc_o, {32'h104, 32'h100});
    nx = 32'h108;
    // fill to full, then a dropped push
    pp(2'b11, 2'b00);
    pp(2'b11, 2'b00);
    check("t2_count6", 64'(count_o), 64'd6);
    check("t2_ready6", 64'(push_ready_o), 64'd1);
    pp(2'b11, 2'b00);
    check("t2_count8", 64'(count_o), 64'd8);
    check("t2_ready8", 64'(push_ready_o), 64'd0);
    cyc(2'b11, 32'h200, insn(32'h200), 32'h204, insn(32'h204), 2'b00, 1'b0);
    check("t2_drop", 64'(count_o), 64'd8);
    // drain two, then steady pop2/push2 across the pointer wrap
    pp(2'b00, 2'b11);
    for (int i = 0; i < 6; i++) begin
      saved = pop_pc_o[63:32];
      pp(2'b11, 2'b11);
      check("t3_count", 64'(count_o), 64'd6);
      check("t3_order", 64'(pop_pc_o[31:0]), 64'(saved + 32'd4));
    end
    // partial handshakes
    pp(2'b00, 2'b11);
    pp(2'b00, 2'b01);
    check("t4_count3", 64'(count_o), 64'd3);
    pp(2'b00, 2'b10);
    check("t4_pop10", 64'(count_o), 64'd3);
    saved = pop_pc_o[63:32];
    pp(2'b00, 2'b01);
    check("t4_pop01", 64'(count_o), 64'd2);
    check("t4_shift", 64'(pop_pc_o[31:0]), 64'(saved));
    pp(2'b10, 2'b00);
    check("t4_push10", 64'(count_o), 64'd2);
    // flush at count 5 with push and pop requested
    pp(2'b11, 2'b00);
    pp(2'b01, 2'b00);
    check("t5_count5", 64'(count_o), 64'd5);
    cyc(2'b11, 32'h400, insn(32'h400), 32'h404, insn(32'h404), 2'b11, 1'b1);
    check("t5_count", 64'(count_o), 64'd0);
    check("t5_pop_valid", 64'(pop_valid_o), 64'd0);
    check("t5_empty_flush", 64'(empty_event_o), 64'd0);
    pp(2'b00, 2'b00);
    check("t5_empty_after", 64'(empty_event_o), 64'd1);
    // asynchronous reset mid-cycle at count 4
    nx = 32'h500;
    pp(2'b11, 2'b00);
    pp(2'b11, 2'b00);
    check("t6_count4", 64'(count_o), 64'd4);
    push_valid_i = 0; pop_ready_i = 0;
    #2 reset = 1;
    #1;
    check("t6_async_count", 64'(count_o), 64'd0);
    check("t6_async_valid", 64'(pop_valid_o), 64'd0);
    check("t6_async_event", 64'(empty_event_o), 64'd0);
    q.delete();
    #2 reset = 0;
    @(posedge clk); #1;
    nx = 32'h300;
    pp(2'b11, 2'b00);
    check("t6_pc_after", pop_pc_o, {32'h304, 32'h300});
    pp(2'b00, 2'b11);
    check("t6_drained", 64'(count_o), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
